// File: rtl/led_blink_gen_if.sv
// Blink waveform bundle from the timebase generator to the LED mode decoder.
// Ports: master drives all eight waveform/strobe signals, slave receives them.
// All signals are registered at the source and change only on SYSCLK edges.
interface led_blink_gen_if;
  logic CLK_1HZ;
  logic CLK_2HZ;
  logic CLK_4HZ;
  logic CLK_4HZ_500MS;
  logic CLK_4HZ_3500MS;
  logic CLK_07S;
  logic TICK_25MS;
  logic FRAME_START;

  modport master (
    output CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS,
    output CLK_07S, TICK_25MS, FRAME_START
  );

  modport slave (
    input CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS,
    input CLK_07S, TICK_25MS, FRAME_START
  );
endinterface

// File: rtl/led_blink_gen.sv
// Purpose: free-running blink timebase; 25 ms tick, 4 s frame, six phase-locked
//   blink waveforms. Latency: outputs update on the same edge as the tick.
//   Backpressure: none, free-running source.
// Ports: SYSCLK clock; RESET sync active-high reset; RESTART sync realign
//   (same effect as RESET); o_led (master modport) carries all waveforms.
// Config macro: LED_BLINK_FAST_SIM_EN forces the prescaler to 4 clocks per
//   tick for simulation; otherwise PRESCALE = CLK_FREQ_HZ/40 (must be >= 2).
module led_blink_gen #(
  parameter int CLK_FREQ_HZ = 33_000_000
) (
  input  logic                   SYSCLK,
  input  logic                   RESET,
  input  logic                   RESTART,
  led_blink_gen_if.master        o_led
);

`ifdef LED_BLINK_FAST_SIM_EN
  localparam int PRESCALE = 4;
`else
  localparam int PRESCALE = CLK_FREQ_HZ / 40;
`endif
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  // Prescaler, frame counter split into /5 and /32 stages, and 0.7 s counter.
  // Frame value f = 5*r_f5 + r_sub5, so f/5 = r_f5, f/10 = r_f5>>1, f/20 = r_f5>>2.
  logic [PW-1:0] r_pre_cnt;
  logic [2:0]    r_sub5;
  logic [4:0]    r_f5;
  logic [4:0]    r_c07;
  logic          r_clk07;

  logic r_clk_1hz;
  logic r_clk_2hz;
  logic r_clk_4hz;
  logic r_clk_4hz_500ms;
  logic r_clk_4hz_3500ms;
  logic r_tick;
  logic r_frame_start;

  logic       w_clr;
  logic       w_tick;
  logic [2:0] w_sub5_nxt;
  logic [4:0] w_f5_nxt;
  logic [4:0] w_c07_nxt;
  logic       w_c07_wrap;
  logic       w_frame_wrap;

  assign w_clr  = RESET | RESTART;
  assign w_tick = (r_pre_cnt == PW'(PRESCALE - 1));

  always_comb begin
    w_sub5_nxt   = r_sub5;
    w_f5_nxt     = r_f5;
    w_c07_nxt    = r_c07;
    w_c07_wrap   = 1'b0;
    w_frame_wrap = 1'b0;
    if (w_tick) begin
      if (r_sub5 == 3'd4) begin
        w_sub5_nxt = 3'd0;
        // 32 groups of 5 ticks = 160 ticks; the 5-bit stage wraps naturally.
        w_f5_nxt   = r_f5 + 5'd1;
        w_frame_wrap = (r_f5 == 5'd31);
      end else begin
        w_sub5_nxt = r_sub5 + 3'd1;
      end
      if (r_c07 == 5'd27) begin
        w_c07_nxt  = 5'd0;
        w_c07_wrap = 1'b1;
      end else begin
        w_c07_nxt  = r_c07 + 5'd1;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (w_clr) begin
      r_pre_cnt        <= '0;
      r_sub5           <= 3'd0;
      r_f5             <= 5'd0;
      r_c07            <= 5'd0;
      r_clk07          <= 1'b0;
      r_clk_1hz        <= 1'b0;
      r_clk_2hz        <= 1'b0;
      r_clk_4hz        <= 1'b0;
      r_clk_4hz_500ms  <= 1'b0;
      r_clk_4hz_3500ms <= 1'b0;
      r_tick           <= 1'b0;
      r_frame_start    <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      r_sub5    <= w_sub5_nxt;
      r_f5      <= w_f5_nxt;
      r_c07     <= w_c07_nxt;
      r_clk07   <= r_clk07 ^ w_c07_wrap;
      // Waveforms decode the next frame value so they move on the tick edge.
      r_clk_4hz        <= w_f5_nxt[0];
      r_clk_2hz        <= w_f5_nxt[1];
      r_clk_1hz        <= w_f5_nxt[2];
      r_clk_4hz_500ms  <= w_f5_nxt[0] & (w_f5_nxt < 5'd4);   // f < 20
      r_clk_4hz_3500ms <= w_f5_nxt[0] & (w_f5_nxt < 5'd28);  // f < 140
      r_tick           <= w_tick;
      r_frame_start    <= w_frame_wrap;
    end
  end

  assign o_led.CLK_1HZ        = r_clk_1hz;
  assign o_led.CLK_2HZ        = r_clk_2hz;
  assign o_led.CLK_4HZ        = r_clk_4hz;
  assign o_led.CLK_4HZ_500MS  = r_clk_4hz_500ms;
  assign o_led.CLK_4HZ_3500MS = r_clk_4hz_3500ms;
  assign o_led.CLK_07S        = r_clk07;
  assign o_led.TICK_25MS      = r_tick;
  assign o_led.FRAME_START    = r_frame_start;

endmodule
